multdiv_seq: RTL and testbench

MULTDIV_SEQ -- requirements
Module: multdiv_seq

---
 rtl/multdiv_pkg.sv | 15 +
 rtl/addsub33.sv | 17 +
 rtl/multdiv_seq.sv | 192 +++++++++++++++++++
 tb/tb_multdiv_seq.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/multdiv_pkg.sv
// Shared types and constants for the sequential signed multiply/divide unit.
package multdiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MULT = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  localparam int          MULT_ITERS   = 16;
  localparam int          DIV_ITERS    = 32;
  localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;

endpackage

// File: rtl/addsub33.sv
// 33-bit combinational add/subtract shared by the Booth and restoring-division steps.
// Zero latency; no flow control.
module addsub33 (
  input  logic [32:0] a_dat,
  input  logic [32:0] b_dat,
  input  logic        sub_en,
  output logic [32:0] sum_dat,
  output logic        cout
);

  logic [33:0] full;

  assign full    = {1'b0, a_dat} + {1'b0, b_dat ^ {33{sub_en}}} + {33'd0, sub_en};
  assign sum_dat = full[32:0];
  assign cout    = full[33];

endmodule

// File: rtl/multdiv_seq.sv
// Sequential signed multiply (radix-4 Booth, 17 edges) / divide (restoring, 33 edges).
// No backpressure: busy stalls the issuing stage, the result is a one-cycle strobe.
module multdiv_seq
  import multdiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [32:0] hi_q, hi_d;       // Booth high accumulator / division partial remainder
  logic [31:0] lo_q, lo_d;       // multiplier bits / quotient bits
  logic        qm1_q, qm1_d;
  logic [31:0] mcand_q, mcand_d; // multiplicand or divisor magnitude
  logic        neg_q, neg_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic [31:0] result_q, result_d;
  logic        exc_q, exc_d;

  logic [32:0] add_a, add_b, add_sum;
  logic        add_sub, add_cout;
  logic [33:0] sum34;
  logic [31:0] a_mag, b_mag;

  addsub33 u_addsub (
    .a_dat   (add_a),
    .b_dat   (add_b),
    .sub_en  (add_sub),
    .sum_dat (add_sum),
    .cout    (add_cout)
  );

  // Exact 34-bit signed sum of the two 33-bit signed operands, needed when adding +/-2M.
  assign sum34 = {add_a[32] ^ add_b[32] ^ add_sub ^ add_cout, add_sum};
  assign a_mag = data_operandA[31] ? (~data_operandA + 32'd1) : data_operandA;
  assign b_mag = data_operandB[31] ? (~data_operandB + 32'd1) : data_operandB;

  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_sub = 1'b0;
    unique case (state_q)
      S_MULT: begin
        add_a = hi_q;
        case ({lo_q[1:0], qm1_q})
          3'b001, 3'b010: add_b = {mcand_q[31], mcand_q};
          3'b011:         add_b = {mcand_q, 1'b0};
          3'b100: begin
            add_b   = {mcand_q, 1'b0};
            add_sub = 1'b1;
          end
          3'b101, 3'b110: begin
            add_b   = {mcand_q[31], mcand_q};
            add_sub = 1'b1;
          end
          default: add_b = '0;
        endcase
      end
      S_DIV: begin
        add_a   = {hi_q[31:0], lo_q[31]};
        add_b   = {1'b0, mcand_q};
        add_sub = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    qm1_d    = qm1_q;
    mcand_d  = mcand_q;
    neg_d    = neg_q;
    dz_d     = dz_q;
    ovf_d    = ovf_q;
    result_d = result_q;
    exc_d    = exc_q;

    unique case (state_q)
      S_MULT: begin
        if (cnt_q < 6'(MULT_ITERS)) begin
          cnt_d = cnt_q + 6'd1;
          hi_d  = {sum34[33], sum34[33:2]};
          lo_d  = {sum34[1:0], lo_q[31:2]};
          qm1_d = lo_q[1];
        end else begin
          result_d = lo_q;
          exc_d    = (hi_q[31:0] != {32{lo_q[31]}});
          state_d  = S_DONE;
        end
      end
      S_DIV: begin
        if (cnt_q < 6'(DIV_ITERS)) begin
          cnt_d = cnt_q + 6'd1;
          // No borrow means the shifted remainder covers the divisor.
          if (add_cout) begin
            hi_d = {1'b0, add_sum[31:0]};
            lo_d = {lo_q[30:0], 1'b1};
          end else begin
            hi_d = {2'b00, hi_q[30:0], lo_q[31]};
            lo_d = {lo_q[30:0], 1'b0};
          end
        end else begin
          state_d = S_DONE;
          if (dz_q) begin
            result_d = '0;
            exc_d    = 1'b1;
          end else if (ovf_q) begin
            result_d = OVF_DIVIDEND;
            exc_d    = 1'b1;
          end else begin
            result_d = neg_q ? (~lo_q + 32'd1) : lo_q;
            exc_d    = 1'b0;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: ;
    endcase

    // A start in any state aborts whatever is in flight.
    if (ctrl_MULT) begin
      state_d = S_MULT;
      cnt_d   = '0;
      hi_d    = '0;
      lo_d    = data_operandB;
      qm1_d   = 1'b0;
      mcand_d = data_operandA;
      neg_d   = 1'b0;
      dz_d    = 1'b0;
      ovf_d   = 1'b0;
    end else if (ctrl_DIV) begin
      state_d = S_DIV;
      cnt_d   = '0;
      hi_d    = '0;
      lo_d    = a_mag;
      qm1_d   = 1'b0;
      mcand_d = b_mag;
      neg_d   = data_operandA[31] ^ data_operandB[31];
      dz_d    = (data_operandB == 32'd0);
      ovf_d   = (data_operandA == OVF_DIVIDEND) && (data_operandB == 32'hFFFF_FFFF);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      qm1_q    <= 1'b0;
      mcand_q  <= '0;
      neg_q    <= 1'b0;
      dz_q     <= 1'b0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      qm1_q    <= qm1_d;
      mcand_q  <= mcand_d;
      neg_q    <= neg_d;
      dz_q     <= dz_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = (state_q == S_DONE);
  assign busy           = (state_q == S_MULT) || (state_q == S_DIV);

endmodule

// File: tb/tb_multdiv_seq.sv
// Randomized scoreboard bench for multdiv_seq against a plain-arithmetic reference model.
module tb_multdiv_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] op_a  = '0;
  logic [31:0] op_b  = '0;
  logic        c_mult = 1'b0;
  logic        c_div  = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_seq #(.WIDTH(32)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (op_a),
    .data_operandB  (op_b),
    .ctrl_MULT      (c_mult),
    .ctrl_DIV       (c_div),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          rdy_cyc;
  } exp_t;

  exp_t        sbq[$];
  exp_t        mon_e;
  int          checks = 0;
  int          errors = 0;
  logic        mon_en = 1'b0;
  logic [31:0] last_res = '0;
  logic        last_exc = 1'b0;
  int          busy_from = 0;
  int          busy_until = 0;

  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic is_mult, input int start);
    exp_t   e;
    longint lx, ly, p, q;
    lx = longint'($signed(x));
    ly = longint'($signed(y));
    if (is_mult) begin
      p     = lx * ly;
      e.res = p[31:0];
      e.exc = (p != longint'($signed(p[31:0])));
    end else if (y == 32'd0) begin
      e.res = 32'd0;
      e.exc = 1'b1;
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.res = 32'h8000_0000;
      e.exc = 1'b1;
    end else begin
      q     = lx / ly;
      e.res = q[31:0];
      e.exc = 1'b0;
    end
    e.rdy_cyc = start + (is_mult ? 17 : 33);
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at edge %0d", name, act, req, cyc);
    end
  endtask

  // Called at a negedge; the start is sampled at the following edge.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y,
                          input logic m, input logic d);
    op_a   = x;
    op_b   = y;
    c_mult = m;
    c_div  = d;
    @(posedge clock);
    #1;
    sbq.delete();
    sbq.push_back(model(x, y, m, cyc));
    busy_from  = cyc;
    busy_until = cyc + (m ? 17 : 33);
    @(negedge clock);
    c_mult = 1'b0;
    c_div  = 1'b0;
    op_a   = $urandom;
    op_b   = $urandom;
  endtask

  task automatic do_reset(input logic with_start);
    reset  = 1'b1;
    c_mult = with_start;
    op_a   = 32'd3;
    op_b   = 32'd4;
    @(posedge clock);
    #1;
    sbq.delete();
    last_res   = '0;
    last_exc   = 1'b0;
    busy_from  = 0;
    busy_until = 0;
    @(negedge clock);
    reset  = 1'b0;
    c_mult = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (sbq.size() > 0 && n < 40) begin
      @(negedge clock);
      n++;
    end
    if (sbq.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: result strobe still pending at edge %0d", cyc);
      sbq.delete();
    end
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 40)) - 32'd20;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clock) begin
    if (mon_en) begin
      check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from && cyc < busy_until)});
      if (data_resultRDY) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rdy: got strobe expected none at edge %0d", cyc);
        end else begin
          mon_e = sbq.pop_front();
          check("rdy_edge", cyc, mon_e.rdy_cyc);
          last_res = mon_e.res;
          last_exc = mon_e.exc;
        end
      end else if (sbq.size() > 0 && cyc >= sbq[0].rdy_cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_rdy: got no strobe expected one at edge %0d", cyc);
        void'(sbq.pop_front());
      end
      check("result", data_result, last_res);
      check("exception", {31'd0, data_exception}, {31'd0, last_exc});
    end
  end

  initial begin
    logic m, d;
    repeat (2) @(posedge clock);
    #1;
    mon_en = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    start_op(32'd7, 32'hFFFF_FFFD, 1'b1, 1'b0);  wait_done();
    start_op(32'h0001_0000, 32'h0001_0000, 1'b1, 1'b0); wait_done();
    start_op(32'hFFFF_FFF9, 32'd2, 1'b0, 1'b1);  wait_done();
    start_op(32'd5, 32'd0, 1'b0, 1'b1);          wait_done();
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1); wait_done();
    start_op(32'd5, 32'd5, 1'b1, 1'b1);          wait_done();

    // Divide aborted by a multiply ten edges later.
    start_op(32'd100, 32'd7, 1'b0, 1'b1);
    repeat (9) @(negedge clock);
    start_op(32'd6, 32'd7, 1'b1, 1'b0);
    wait_done();
    repeat (2) @(negedge clock);

    // Reset eight edges into a multiply; nothing may complete afterwards.
    start_op(32'd3, 32'd4, 1'b1, 1'b0);
    repeat (7) @(negedge clock);
    do_reset(1'b0);
    repeat (34) @(negedge clock);

    // Reset wins over a start in the same cycle.
    do_reset(1'b1);
    repeat (20) @(negedge clock);

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       begin m = 1'b1; d = 1'b0; end
        1:       begin m = 1'b0; d = 1'b1; end
        default: begin m = 1'b1; d = 1'b1; end
      endcase
      start_op(pick_operand(), pick_operand(), m, d);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 15)) @(negedge clock);
      end else begin
        wait_done();
        repeat ($urandom_range(0, 3)) @(negedge clock);
      end
    end
    wait_done();
    repeat (3) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
